// File: rtl/tone_gen.sv
// Glitch-free square-wave tone generator fed by the note table's half-period divider (0 = rest).
// Optional TONE_VOLUME_EN adds i_volume and a 2-bit PWM gate on the output. Load: 1 cycle from silence, else at a half-period boundary.
module tone_gen #(
  parameter int PRESCALE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_div_in,
  input  logic       i_div_valid,
  output logic       o_div_ready,
  input  logic       i_enable,
  output logic       o_tone_out,
`ifdef TONE_VOLUME_EN
  input  logic [1:0] i_volume,
`endif
  output logic       o_edge
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic [7:0]    r_pending;
  logic          r_pend_full;
  logic [7:0]    r_active;
  logic [7:0]    r_hp_cnt;
  logic          r_square;
  logic          r_edge;

  logic w_run;
  logic w_tick;
  logic w_boundary;

  assign w_run      = i_enable && (r_active != 8'd0);
  assign w_tick     = w_run && (r_presc == PMAX);
  assign w_boundary = w_tick && (r_hp_cnt == r_active - 8'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc     <= '0;
      r_pending   <= 8'd0;
      r_pend_full <= 1'b0;
      r_active    <= 8'd0;
      r_hp_cnt    <= 8'd0;
      r_square    <= 1'b0;
      r_edge      <= 1'b0;
    end else begin
      r_edge <= 1'b0;
      // Accept and load are exclusive: accept needs an empty slot, load a full one.
      if (i_div_valid && !r_pend_full) begin
        r_pending   <= i_div_in;
        r_pend_full <= 1'b1;
      end else if (r_pend_full && (!w_run || w_boundary)) begin
        r_active    <= r_pending;
        r_pend_full <= 1'b0;
      end

      if (!w_run) begin
        r_presc  <= '0;
        r_hp_cnt <= 8'd0;
        r_square <= 1'b0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_boundary) begin
          r_hp_cnt <= 8'd0;
          // A rest loaded at the boundary drops the output without a toggle.
          if (r_pend_full && (r_pending == 8'd0)) begin
            r_square <= 1'b0;
          end else begin
            r_square <= ~r_square;
            r_edge   <= 1'b1;
          end
        end else if (w_tick) begin
          r_hp_cnt <= r_hp_cnt + 8'd1;
        end
      end
    end
  end

  assign o_div_ready = !r_pend_full;
  assign o_edge      = r_edge;

`ifdef TONE_VOLUME_EN
  logic [1:0] r_pwm_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt <= 2'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 2'd1;
    end
  end

  assign o_tone_out = r_square && (r_pwm_cnt <= i_volume);
`else
  assign o_tone_out = r_square;
`endif

endmodule
